// File: rtl/pe_tensor_pkg.sv
// Shared helpers for the tensor PE: tap-count and width derivation, packed-slice offsets and
// output saturation (optional ReLU clamp).
package pe_tensor_pkg;

   function automatic int unsigned kk_of(input int unsigned k);
      return k * k;
   endfunction

   // Width needed to sum KK full-precision products without overflow.
   function automatic int unsigned sum_width(input int unsigned dw, input int unsigned kk);
      return 2 * dw + $clog2(kk);
   endfunction

   function automatic int unsigned slice_lsb(input int unsigned lane, input int unsigned tap,
                                             input int unsigned kk, input int unsigned dw);
      return (lane * kk + tap) * dw;
   endfunction

   // Caller sign-extends the accumulator to 64 bits and truncates the result to ow bits.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned ow, input bit relu);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (relu && v < 0) return 64'sd0;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/pe_lane.sv
// One output-channel lane: KK signed products (S1), tap sum (S2), group accumulator (S3).
// Control (valid/first/last) travels in the parent; this lane only holds the datapath.
module pe_lane
   import pe_tensor_pkg::*;
#(
   parameter int unsigned KK = 9,
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               s0_fire,
   input  logic               s1_valid,
   input  logic               s2_valid,
   input  logic               s2_first,
   input  logic [KK*DW-1:0]   x,
   input  logic [KK*DW-1:0]   w,
   output logic [AW-1:0]      acc_next
);

   localparam int unsigned PW = 2 * DW;
   localparam int unsigned SW = sum_width(DW, KK);

   logic signed [PW-1:0] prod_d [KK];
   logic signed [PW-1:0] prod_q [KK];
   logic signed [SW-1:0] tap_sum;
   logic signed [AW-1:0] sum_q;
   logic signed [AW-1:0] acc_q;

   always_comb begin
      for (int j = 0; j < KK; j++) begin
         prod_d[j] = $signed(x[slice_lsb(0, j, KK, DW) +: DW]) *
                     $signed(w[slice_lsb(0, j, KK, DW) +: DW]);
      end
   end

   always_comb begin
      tap_sum = '0;
      for (int j = 0; j < KK; j++) begin
         tap_sum = tap_sum + SW'(prod_q[j]);
      end
   end

   assign acc_next = s2_first ? sum_q : acc_q + sum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_q <= '{default: '0};
         sum_q  <= '0;
         acc_q  <= '0;
      end else begin
         if (s0_fire) prod_q <= prod_d;
         if (en && s1_valid) sum_q <= AW'(tap_sum);
         if (en && s2_valid) acc_q <= acc_next;
      end
   end

endmodule

// File: rtl/pe_tensor_acc.sv
// N-lane pipelined KxK tensor PE with double-buffered weights and a stalling result register.
// Define PE_RELU_EN to clamp negative results to zero before saturation.
module pe_tensor_acc
   import pe_tensor_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned K  = 3,
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 32,
   parameter int unsigned OW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 w_valid,
   input  logic [N*K*K*DW-1:0]  w_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*K*K*DW-1:0]  in_data,
   input  logic                 in_first,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*OW-1:0]      out_data
);

   localparam int unsigned KK = kk_of(K);
   localparam int unsigned WW = N * KK * DW;
`ifdef PE_RELU_EN
   localparam bit Relu = 1'b1;
`else
   localparam bit Relu = 1'b0;
`endif

   logic [WW-1:0]   shadow_q, active_q, w_eff;
   logic            pending_q, pending_d;
   logic            en, fire, swap, load;
   logic            v1_q, f1_q, l1_q, v2_q, f2_q, l2_q;
   logic            out_valid_q, out_valid_d;
   logic [N*OW-1:0] out_data_q, out_data_d, sat_res;
   logic [AW-1:0]   acc_next [N];

   assign en       = !(out_valid_q && !out_ready);
   assign in_ready = en;
   assign fire     = in_valid && en;
   // A swapping beat must already see the new filters, so bypass the active bank.
   assign swap     = fire && in_first && pending_q;
   assign w_eff    = swap ? shadow_q : active_q;
   assign load     = en && v2_q && l2_q;

   always_comb begin
      pending_d = pending_q;
      if (swap) pending_d = 1'b0;
      if (w_valid) pending_d = 1'b1;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = sat_res;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      localparam int unsigned Lsb = slice_lsb(i, 0, KK, DW);

      pe_lane #(
         .KK (KK),
         .DW (DW),
         .AW (AW)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .s0_fire  (fire),
         .s1_valid (v1_q),
         .s2_valid (v2_q),
         .s2_first (f2_q),
         .x        (in_data[Lsb +: KK*DW]),
         .w        (w_eff[Lsb +: KK*DW]),
         .acc_next (acc_next[i])
      );

      assign sat_res[i*OW +: OW] = OW'(saturate(64'($signed(acc_next[i])), OW, Relu));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q    <= '0;
         active_q    <= '0;
         pending_q   <= 1'b0;
         v1_q        <= 1'b0;
         f1_q        <= 1'b0;
         l1_q        <= 1'b0;
         v2_q        <= 1'b0;
         f2_q        <= 1'b0;
         l2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (w_valid) shadow_q <= w_data;
         if (swap) active_q <= shadow_q;
         pending_q <= pending_d;
         if (en) begin
            v1_q <= fire;
            f1_q <= in_first;
            l1_q <= in_last;
            v2_q <= v1_q;
            f2_q <= f1_q;
            l2_q <= l1_q;
         end
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule
